// File: rtl/bcd_pkg.sv
// Shared constants and types for the iterative binary-to-BCD converter.
package bcd_pkg;

  localparam int BIN_W  = 16;
  localparam int DIGITS = 5;
  localparam int BCD_W  = 4 * DIGITS;
  localparam int CNT_W  = 5;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  typedef logic [CNT_W-1:0] count_t;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more.
module bcd_digit_adjust (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  // A digit >= 5 would reach >= 10 after the next shift; +3 makes it carry into the next digit.
  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/binary_to_bcd.sv
// Sequential double-dabble converter: 16-bit unsigned binary to five BCD digits, one shift per clock.
module binary_to_bcd #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [BIN_W-1:0] bin,
  output logic             ready,
  output logic             out_valid,
  output logic [15:0]      bcd,
  output logic [3:0]       bcd_ten_thousands,
  output logic             overflow
);

  import bcd_pkg::*;

  localparam int DIG_W  = 4 * DIGITS;
  localparam int COMB_W = DIG_W + BIN_W;
  localparam count_t LAST_ITER = count_t'(BIN_W - 1);

  state_t              state, state_next;
  logic [BIN_W-1:0]    shreg;
  logic [DIG_W-1:0]    scratch;
  logic [DIG_W-1:0]    scratch_adj;
  logic [COMB_W-1:0]   comb_next;
  count_t              count;
  logic                accept;
  logic                last_iter;

  assign ready     = (state == IDLE);
  assign accept    = in_valid && ready;
  assign last_iter = (state == SHIFT) && (count == LAST_ITER);

  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit   (scratch[4*d +: 4]),
      .adjusted(scratch_adj[4*d +: 4])
    );
  end

  // Adjust first, then shift the whole {scratch, shift register} left by one.
  assign comb_next = {scratch_adj, shreg} << 1;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (accept)    state_next = SHIFT;
      SHIFT: if (last_iter) state_next = IDLE;
      default:              state_next = IDLE;
    endcase
  end

  // NOTE: the async reset clears the result registers too, so an aborted conversion leaves zeros.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg             <= '0;
      scratch           <= '0;
      count             <= '0;
      out_valid         <= 1'b0;
      bcd               <= '0;
      bcd_ten_thousands <= '0;
      overflow          <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        shreg   <= bin;
        scratch <= '0;
        count   <= '0;
      end else if (state == SHIFT) begin
        {scratch, shreg} <= comb_next;
        count            <= count + 1'b1;
        // Results come straight from the final shifted scratch, never from intermediate contents.
        if (last_iter) begin
          bcd               <= comb_next[BIN_W +: 16];
          bcd_ten_thousands <= comb_next[BIN_W+16 +: 4];
          overflow          <= |comb_next[BIN_W+16 +: 4];
          out_valid         <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_binary_to_bcd.sv
// Scoreboard bench for binary_to_bcd: decimal reference model, randomized and directed values.
module tb_binary_to_bcd;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] bin;
  logic        ready;
  logic        out_valid;
  logic [15:0] bcd;
  logic [3:0]  bcd_ten_thousands;
  logic        overflow;

  typedef struct packed {
    logic [3:0]  tt;
    logic [15:0] low;
    logic        ovf;
  } res_t;

  res_t        sb[$];
  int unsigned acc_q[$];
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  binary_to_bcd dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .bin              (bin),
    .ready            (ready),
    .out_valid        (out_valid),
    .bcd              (bcd),
    .bcd_ten_thousands(bcd_ten_thousands),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: decimal digits by plain division, independent of any shift/add scheme.
  function automatic res_t model(input int unsigned v);
    res_t r;
    r.tt  = 4'(v / 10000);
    r.low = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    r.ovf = (v > 9999);
    return r;
  endfunction

  // Monitor: every out_valid pulse must match the oldest expected result, 16 edges after accept.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        res_t        e;
        int unsigned a;
        e = sb.pop_front();
        a = acc_q.pop_front();
        check("bcd", 32'(bcd), 32'(e.low));
        check("ten_thousands", 32'(bcd_ten_thousands), 32'(e.tt));
        check("overflow", 32'(overflow), 32'(e.ovf));
        check("latency", cyc - a, 32'd16);
      end
    end
  end

  // Waits (bounded) for ready, presents the value for one accepting edge, then scrambles bin.
  task automatic send(input logic [15:0] v);
    int t = 0;
    @(negedge clk);
    while (!ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!ready) check("ready_timeout", 32'd0, 32'd1);
    bin      = v;
    in_valid = 1'b1;
    sb.push_back(model(32'(v)));
    acc_q.push_back(cyc + 1);
    @(negedge clk);
    in_valid = 1'b0;
    bin      = 16'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_bcd"}, 32'(bcd), 32'd0);
    check({tag, "_tt"}, 32'(bcd_ten_thousands), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    logic [15:0] dir [12];
    int          t;
    dir = '{16'd0, 16'd1234, 16'd9999, 16'd10000, 16'd65535, 16'd1,
            16'd9, 16'd10, 16'd99, 16'd100, 16'd999, 16'd1000};

    rst      = 1'b1;
    in_valid = 1'b0;
    bin      = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("reset");

    foreach (dir[i]) begin
      send(dir[i]);
      drain();
    end

    // Busy ignore: a stray pulse while converting 42 must not be queued.
    send(16'd42);
    repeat (3) @(negedge clk);
    check("busy_ready", 32'(ready), 32'd0);
    bin      = 16'd777;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    // Back-to-back: present 777 in the out_valid cycle, accepted on the very next edge.
    t = 0;
    while (!out_valid && t < 30) begin
      @(negedge clk);
      t++;
    end
    check("b2b_out_valid_seen", 32'(out_valid), 32'd1);
    check("b2b_ready_in_pulse", 32'(ready), 32'd1);
    bin      = 16'd777;
    in_valid = 1'b1;
    sb.push_back(model(32'd777));
    acc_q.push_back(cyc + 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_busy", 32'(ready), 32'd0);
    drain();

    // Reset mid-conversion: outputs clear and the aborted request never reports.
    send(16'd4321);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    acc_q.delete();
    @(negedge clk);
    check_reset_values("midrst");
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_idle_bcd", 32'(bcd), 32'd0);
    send(16'd4321);
    drain();

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(16'($urandom_range(0, 65535)));
      if ($urandom_range(0, 1) == 1) drain();
    end
    drain();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
